// File: rtl/updn_mod_counter.sv
// updn_mod_counter: WIDTH-bit up/down counter with programmable modulo limit
// (range 0..cnt_max), synchronous load, count enable and registered wrap
// reporting (wrap_up / wrap_dn pulses, sticky wrap_seen).
// Optional saturation mode is built when UPDN_MOD_COUNTER_SAT_EN is defined:
// adds input sat_mode and registered output at_limit.
// Reset is synchronous, active-high; reset > load > count > hold.
module updn_mod_counter #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_cnt_,
   input  logic             updn_cnt,
   input  logic             count_enb,
   input  logic [WIDTH-1:0] data_in,
   input  logic [WIDTH-1:0] cnt_max,
`ifdef UPDN_MOD_COUNTER_SAT_EN
   input  logic             sat_mode,
   output logic             at_limit,
`endif
   output logic [WIDTH-1:0] data_out,
   output logic             wrap_up,
   output logic             wrap_dn,
   output logic             wrap_seen
);

   logic [WIDTH-1:0] r_cnt;
   logic             r_wrap_up;
   logic             r_wrap_dn;
   logic             r_wrap_seen;

   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_wrap_up_nxt;
   logic             w_wrap_dn_nxt;
   logic             w_wrap_seen_nxt;
   logic             w_sat_hit;

   // One bit of headroom so the all-ones limit never truncates silently.
   logic [WIDTH:0]   w_cnt_ext;
   logic [WIDTH:0]   w_max_ext;
   logic [WIDTH:0]   w_inc_ext;
   logic             w_at_top;
   logic             w_at_bot;
   logic [WIDTH-1:0] w_load_val;
   logic             w_sat_mode;

   assign w_cnt_ext  = {1'b0, r_cnt};
   assign w_max_ext  = {1'b0, cnt_max};
   assign w_inc_ext  = w_cnt_ext + {{WIDTH{1'b0}}, 1'b1};
   // A lowered cnt_max below the count still wraps on the next up count.
   assign w_at_top   = (w_cnt_ext >= w_max_ext);
   assign w_at_bot   = (r_cnt == '0);
   assign w_load_val = (data_in > cnt_max) ? cnt_max : data_in;

`ifdef UPDN_MOD_COUNTER_SAT_EN
   assign w_sat_mode = sat_mode;
`else
   assign w_sat_mode = 1'b0;
`endif

   // Next-state decode: load > count > hold.
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_wrap_up_nxt   = 1'b0;
      w_wrap_dn_nxt   = 1'b0;
      w_wrap_seen_nxt = r_wrap_seen;
      w_sat_hit       = 1'b0;
      if (!ld_cnt_) begin
         w_cnt_nxt       = w_load_val;
         w_wrap_seen_nxt = 1'b0;
      end else if (count_enb) begin
         if (updn_cnt) begin
            if (w_at_top) begin
               if (w_sat_mode) begin
                  w_cnt_nxt = cnt_max;
                  w_sat_hit = 1'b1;
               end else begin
                  w_cnt_nxt       = '0;
                  w_wrap_up_nxt   = 1'b1;
                  w_wrap_seen_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = w_inc_ext[WIDTH-1:0];
            end
         end else begin
            if (w_at_bot) begin
               if (w_sat_mode) begin
                  w_cnt_nxt = '0;
                  w_sat_hit = 1'b1;
               end else begin
                  w_cnt_nxt       = cnt_max;
                  w_wrap_dn_nxt   = 1'b1;
                  w_wrap_seen_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Counter and wrap flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= RST_VAL;
         r_wrap_up   <= 1'b0;
         r_wrap_dn   <= 1'b0;
         r_wrap_seen <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_wrap_up   <= w_wrap_up_nxt;
         r_wrap_dn   <= w_wrap_dn_nxt;
         r_wrap_seen <= w_wrap_seen_nxt;
      end
   end

`ifdef UPDN_MOD_COUNTER_SAT_EN
   logic r_at_limit;

   // at_limit follows the most recent count attempt; hold keeps it, load clears it.
   always_ff @(posedge clk) begin
      if (rst || !ld_cnt_) begin
         r_at_limit <= 1'b0;
      end else if (count_enb) begin
         r_at_limit <= w_sat_hit;
      end
   end

   assign at_limit = r_at_limit;
`else
   logic w_unused;
   assign w_unused = w_sat_hit;
`endif

   assign data_out  = r_cnt;
   assign wrap_up   = r_wrap_up;
   assign wrap_dn   = r_wrap_dn;
   assign wrap_seen = r_wrap_seen;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Scoreboard bench for updn_mod_counter (WIDTH=8, RST_VAL=0).
// Build with UPDN_MOD_COUNTER_SAT_EN to include the saturation scenario.
module tb_updn_mod_counter;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             ld_cnt_ = 1'b1;
   logic             updn_cnt = 1'b1;
   logic             count_enb = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic [WIDTH-1:0] cnt_max = 8'd255;
   logic [WIDTH-1:0] data_out;
   logic             wrap_up;
   logic             wrap_dn;
   logic             wrap_seen;
   logic             sat_mode = 1'b0;
`ifdef UPDN_MOD_COUNTER_SAT_EN
   logic             at_limit;
`endif

   updn_mod_counter #(.WIDTH(WIDTH), .RST_VAL(8'd0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ld_cnt_   (ld_cnt_),
      .updn_cnt  (updn_cnt),
      .count_enb (count_enb),
      .data_in   (data_in),
      .cnt_max   (cnt_max),
`ifdef UPDN_MOD_COUNTER_SAT_EN
      .sat_mode  (sat_mode),
      .at_limit  (at_limit),
`endif
      .data_out  (data_out),
      .wrap_up   (wrap_up),
      .wrap_dn   (wrap_dn),
      .wrap_seen (wrap_seen)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      bit up;
      bit dn;
      bit seen;
      bit lim;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state.
   int m_cnt  = 0;
   bit m_seen = 1'b0;
   bit m_lim  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply one cycle of controls, predict, then compare after the edge.
   task automatic step(input bit r, input bit ld_n, input bit up, input bit enb,
                       input int din, input int mx, input bit sat, input string tag);
      exp_t e;
      rst = r; ld_cnt_ = ld_n; updn_cnt = up; count_enb = enb;
      data_in = 8'(din); cnt_max = 8'(mx); sat_mode = sat;
`ifndef UPDN_MOD_COUNTER_SAT_EN
      sat = 1'b0;
`endif
      e.up = 1'b0; e.dn = 1'b0;
      if (r) begin
         m_cnt = 0; m_seen = 1'b0; m_lim = 1'b0;
      end else if (!ld_n) begin
         m_cnt = (din < mx) ? din : mx; m_seen = 1'b0; m_lim = 1'b0;
      end else if (enb) begin
         m_lim = 1'b0;
         if (up) begin
            if (m_cnt >= mx) begin
               if (sat) begin m_cnt = mx; m_lim = 1'b1; end
               else begin m_cnt = 0; e.up = 1'b1; m_seen = 1'b1; end
            end else m_cnt = m_cnt + 1;
         end else begin
            if (m_cnt == 0) begin
               if (sat) m_lim = 1'b1;
               else begin m_cnt = mx; e.dn = 1'b1; m_seen = 1'b1; end
            end else m_cnt = m_cnt - 1;
         end
      end
      e.cnt = m_cnt; e.seen = m_seen; e.lim = m_lim;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, ".data_out"},  32'(data_out),  32'(e.cnt));
         check({tag, ".wrap_up"},   32'(wrap_up),   32'(e.up));
         check({tag, ".wrap_dn"},   32'(wrap_dn),   32'(e.dn));
         check({tag, ".wrap_seen"}, 32'(wrap_seen), 32'(e.seen));
         check({tag, ".one_hot"},   32'(wrap_up & wrap_dn), 32'd0);
`ifdef UPDN_MOD_COUNTER_SAT_EN
         check({tag, ".at_limit"},  32'(at_limit),  32'(e.lim));
`endif
      end
   endtask

   initial begin
      // Reset held two cycles with a load pending, then load 0x55.
      step(1, 0, 1, 0, 8'h55, 255, 0, "rst0");
      step(1, 0, 1, 0, 8'h55, 255, 0, "rst1");
      check("rst.data_out_zero", 32'(data_out), 32'd0);
      step(0, 0, 1, 0, 8'h55, 255, 0, "ld55");
      // Load clamp to cnt_max.
      step(0, 0, 1, 1, 200, 10, 0, "clamp");
      // Up wrap at cnt_max=9.
      step(0, 0, 1, 0, 7, 9, 0, "ld7");
      for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 9, 0, "upwrap");
      // Down wrap through 0 at cnt_max=255, then hold.
      step(0, 0, 0, 0, 1, 255, 0, "ld1");
      for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 255, 0, "dnwrap");
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 255, 0, "hold");
      check("hold.value_254", 32'(data_out), 32'd254);
      // Load beats count; reset beats load.
      step(0, 0, 1, 0, 5, 20, 0, "ld5");
      step(0, 0, 1, 1, 3, 20, 0, "ld_over_cnt");
      step(1, 0, 1, 1, 9, 20, 0, "rst_over_ld");
      // cnt_max == 0: every enabled count wraps, value stays 0.
      step(0, 1, 1, 1, 0, 0, 0, "max0_up");
      step(0, 1, 0, 1, 0, 0, 0, "max0_dn");
      // Lowered cnt_max below the count: down decrements, up wraps.
      step(0, 0, 1, 0, 50, 100, 0, "ld50");
      step(0, 1, 0, 1, 0, 10, 0, "low_dn");
      step(0, 1, 1, 1, 0, 10, 0, "low_up");
`ifdef UPDN_MOD_COUNTER_SAT_EN
      step(0, 0, 1, 0, 3, 4, 1, "sat_ld3");
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 4, 1, "sat_up");
      step(0, 1, 0, 1, 0, 4, 1, "sat_away");
`endif
      // Random traffic with a small set of limits including the boundaries.
      for (int i = 0; i < 300; i++) begin
         int mx;
         int sel;
         sel = $urandom_range(0, 4);
         mx  = (sel == 0) ? 0 : (sel == 1) ? 255 : (sel == 2) ? 1 : $urandom_range(2, 12);
         step(($urandom_range(0, 40) == 0), ($urandom_range(0, 12) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
              $urandom_range(0, 255), mx, 1'($urandom_range(0, 1)), "rand");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/updn_mod_counter.md
Name: updn_mod_counter

Overview:
- Synthesizable 8-bit (parameterizable) up/down counter with programmable modulo limit: synchronous load, count enable and direction control.
- This is the design-side block that the team's counter assertion checker binds to. Port names and semantics match the checker: clk, ld_cnt_, updn_cnt, count_enb, data_in, data_out.
- Adds wrap/terminal-count reporting for downstream timers and rate dividers.

Parameters:
- WIDTH, 8, counter/data width in bits.
- RST_VAL, 0, value data_out takes on reset; must be <= the cnt_max value in use after reset.

Ports:
- clk  input  1  single clock; all state changes on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- ld_cnt_  input  1  active-low synchronous load strobe.
- updn_cnt  input  1  direction: 1 = count up, 0 = count down.
- count_enb  input  1  count enable, active-high.
- data_in  input  WIDTH  load value.
- cnt_max  input  WIDTH  modulo limit; counting range is 0..cnt_max inclusive.
- data_out  output  WIDTH  registered count value.
- wrap_up  output  1  one-cycle pulse: up-count wrapped cnt_max -> 0.
- wrap_dn  output  1  one-cycle pulse: down-count wrapped 0 -> cnt_max.
- wrap_seen  output  1  sticky flag: any wrap since last reset or load.

Behaviour:
- All outputs are registered. None are combinational from inputs.
- Reset: if rst==1 at posedge clk, then next cycle data_out=RST_VAL, wrap_up=0, wrap_dn=0, wrap_seen=0.
- Rst overrides every other input.
- Priority at each posedge, rst==0: load > count > hold.
- Load (ld_cnt_==0):
  - data_out <= min(data_in, cnt_max).
  - wrap_up=0, wrap_dn=0, wrap_seen <= 0.
  - count_enb and updn_cnt are ignored.
- Hold (ld_cnt_==1, count_enb==0):
  - data_out keeps its previous value.
  - wrap_up=0, wrap_dn=0, wrap_seen unchanged.
- Count up (ld_cnt_==1, count_enb==1, updn_cnt==1):
  - If data_out >= cnt_max: data_out <= 0, wrap_up <= 1, wrap_seen <= 1.
  - Else: data_out <= data_out+1, wrap_up <= 0.
- Count down (ld_cnt_==1, count_enb==1, updn_cnt==0):
  - If data_out == 0: data_out <= cnt_max, wrap_dn <= 1, wrap_seen <= 1.
  - Else: data_out <= data_out-1, wrap_dn <= 0.
  - If cnt_max has been lowered below data_out, the next down count still decrements normally.
- Latency: exactly one clock from sampled control to data_out.
  - Checker form: data_out == $past(data_out) +/- 1 mod (cnt_max+1).
- Wrap pulse timing: wrap_up/wrap_dn is asserted in the same cycle data_out first shows the wrapped value. It is deasserted the next cycle unless another wrap occurs.
- wrap_up and wrap_dn are never both 1.
- cnt_max == 0: counter stays at 0.
  - Every enabled count (either direction) produces a wrap pulse.
- cnt_max == all-ones: natural modular WIDTH-bit wrap. Arithmetic is done at WIDTH+1 bits internally, with no silent truncation.
- cnt_max may change at any cycle; the value sampled at the edge is used.
- Reset mid-count or in the same cycle as a load: reset wins, and no wrap pulse is produced.
- updn_cnt or count_enb toggling every cycle is legal; each edge is evaluated independently.

Optional Feature:
- Macro: UPDN_MOD_COUNTER_SAT_EN.
- Defined:
  - Adds input port sat_mode (1 bit) and output port at_limit (1 bit, registered, reset 0).
  - When sat_mode==1, counting up at cnt_max holds at cnt_max, and counting down at 0 holds at 0.
  - No wrap pulses in this case, and wrap_seen is unchanged.
  - at_limit=1 whenever the registered data_out equals 0 (last count direction down) or cnt_max (last count direction up) after a saturated attempt. It clears on load, reset, or any count away from the limit.
  - When sat_mode==0, behaviour is identical to the undefined case.
- Undefined:
  - Ports sat_mode and at_limit do not exist.
  - Counter always wraps as described above.

Test Plan:
- Reset: rst=1 for 2 cycles with ld_cnt_=0, data_in=8'h55 -> data_out=0, wrap_up=wrap_dn=wrap_seen=0; after rst drops and one load cycle -> data_out=8'h55.
- Load clamp: cnt_max=10, ld_cnt_=0, data_in=200 -> data_out=10 next cycle, wrap_seen cleared.
- Up wrap: cnt_max=9, load 7, count_enb=1, updn_cnt=1 for 4 cycles -> data_out 8,9,0,1; wrap_up=1 only in the cycle data_out=0; wrap_seen=1 thereafter.
- Down wrap / hold: cnt_max=255, load 1, count down 3 cycles -> 0,255,254 with wrap_dn pulse at 255; then count_enb=0 for 3 cycles -> data_out holds 254.
- Priority/simultaneity: data_out=5, ld_cnt_=0, count_enb=1, data_in=3 -> data_out=3; next edge rst=1 and ld_cnt_=0 -> data_out=0.
- With UPDN_MOD_COUNTER_SAT_EN, sat_mode=1, cnt_max=4, load 3, count up 3 cycles -> 4,4,4, at_limit=1 from the second cycle, wrap_up never asserted.
